// File: rtl/lb_stream_master.sv
// ---------------------------------------------------------------------------
// lb_stream_master
//
// Local-bus initiator fed by a byte-stream command channel.
//   Write packet : 'W' A2 A1 A0 D3 D2 D1 D0  -> one write strobe, reply 'w'
//   Read packet  : 'R' A2 A1 A0              -> one read strobe, reply
//                                               'r' D3 D2 D1 D0
//   Any other first byte                     -> reply '?', err_count+1
//
// Ports
//   lb_clk, reset          : clock, asynchronous active-high reset
//   cmd_data/valid/ready   : command byte stream in (valid/ready handshake)
//   rsp_data/valid/ready   : response byte stream out (valid/ready handshake)
//   lb_addr, lb_data_out   : bus address / write data (hold between packets)
//   lb_strobe, lb_rd,
//   lb_write               : transaction strobe and qualifiers
//   lb_rd_valid, lb_din    : read-data capture pulse, responder read data
//   txn_count, err_count   : completed transactions (wraps), bad opcodes
//                            (saturates)
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module lb_stream_master #(
    parameter int          READ_DELAY = 3,
    parameter logic [7:0]  OP_WRITE   = 8'h57,
    parameter logic [7:0]  OP_READ    = 8'h52
) (
    input  logic        lb_clk,
    input  logic        reset,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [23:0] lb_addr,
    output logic [31:0] lb_data_out,
    output logic        lb_strobe,
    output logic        lb_rd,
    output logic        lb_write,
    output logic        lb_rd_valid,
    input  logic [31:0] lb_din,
    output logic [15:0] txn_count,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        STROBE = 3'd3,
        RWAIT  = 3'd4,
        RSP    = 3'd5
    } state_t;

    localparam logic [3:0] C_DELAY = 4'(READ_DELAY);

    // registered state
    state_t      r_state;
    logic [1:0]  r_idx;
    logic        r_is_read;
    logic [23:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic [39:0] r_rsp_buf;     // outgoing bytes, current byte in [39:32]
    logic [2:0]  r_rsp_left;
    logic        r_rsp_err;     // current response is the '?' reply
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic        r_strobe;
    logic        r_rd;
    logic        r_write;
    logic        r_rd_valid;
    logic [15:0] r_txn_count;
    logic [7:0]  r_err_count;

    // next-state values
    state_t      w_state;
    logic [1:0]  w_idx;
    logic        w_is_read;
    logic [23:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_cnt;
    logic [39:0] w_rsp_buf;
    logic [2:0]  w_rsp_left;
    logic        w_rsp_err;
    logic        w_cmd_ready;
    logic        w_rsp_valid;
    logic        w_strobe;
    logic        w_rd;
    logic        w_write;
    logic        w_rd_valid;
    logic [15:0] w_txn_count;
    logic [7:0]  w_err_count;

    logic        w_cmd_fire;
    logic        w_rsp_fire;

    assign w_cmd_fire = cmd_valid & r_cmd_ready;
    assign w_rsp_fire = r_rsp_valid & rsp_ready;

    // Next-state and next-output computation for the packet FSM
    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_is_read   = r_is_read;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_cnt       = r_cnt;
        w_rsp_buf   = r_rsp_buf;
        w_rsp_left  = r_rsp_left;
        w_rsp_err   = r_rsp_err;
        w_txn_count = r_txn_count;
        w_err_count = r_err_count;

        case (r_state)
            IDLE: begin
                if (w_cmd_fire) begin
                    if (cmd_data == OP_WRITE) begin
                        w_is_read = 1'b0;
                        w_idx     = 2'd0;
                        w_state   = ADDR;
                    end else if (cmd_data == OP_READ) begin
                        w_is_read = 1'b1;
                        w_idx     = 2'd0;
                        w_state   = ADDR;
                    end else begin
                        w_rsp_buf  = {8'h3F, 32'h0000_0000};
                        w_rsp_left = 3'd1;
                        w_rsp_err  = 1'b1;
                        w_state    = RSP;
                        if (r_err_count != 8'hFF) begin
                            w_err_count = r_err_count + 8'd1;
                        end else begin
                            w_err_count = r_err_count;
                        end
                    end
                end else begin
                    w_state = IDLE;
                end
            end

            ADDR: begin
                if (w_cmd_fire) begin
                    case (r_idx)
                        2'd0:    w_addr[23:16] = cmd_data;
                        2'd1:    w_addr[15:8]  = cmd_data;
                        default: w_addr[7:0]   = cmd_data;
                    endcase
                    if (r_idx == 2'd2) begin
                        w_idx   = 2'd0;
                        w_state = r_is_read ? STROBE : DATA;
                    end else begin
                        w_idx = r_idx + 2'd1;
                    end
                end else begin
                    w_state = ADDR;
                end
            end

            DATA: begin
                if (w_cmd_fire) begin
                    case (r_idx)
                        2'd0:    w_wdata[31:24] = cmd_data;
                        2'd1:    w_wdata[23:16] = cmd_data;
                        2'd2:    w_wdata[15:8]  = cmd_data;
                        default: w_wdata[7:0]   = cmd_data;
                    endcase
                    if (r_idx == 2'd3) begin
                        w_idx   = 2'd0;
                        w_state = STROBE;
                    end else begin
                        w_idx = r_idx + 2'd1;
                    end
                end else begin
                    w_state = DATA;
                end
            end

            STROBE: begin
                if (r_is_read) begin
                    // r_cnt tracks cycles elapsed since the strobe cycle
                    w_cnt   = 4'd1;
                    w_state = RWAIT;
                end else begin
                    w_rsp_buf  = {8'h77, 32'h0000_0000};
                    w_rsp_left = 3'd1;
                    w_rsp_err  = 1'b0;
                    w_state    = RSP;
                end
            end

            RWAIT: begin
                if (r_cnt == C_DELAY) begin
                    w_rsp_buf  = {8'h72, lb_din};
                    w_rsp_left = 3'd5;
                    w_rsp_err  = 1'b0;
                    w_state    = RSP;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end

            RSP: begin
                if (w_rsp_fire) begin
                    // shifting in zeros leaves rsp_data at 0 once drained
                    w_rsp_buf = {r_rsp_buf[31:0], 8'h00};
                    if (r_rsp_left == 3'd1) begin
                        w_rsp_left = 3'd0;
                        w_state    = IDLE;
                        if (!r_rsp_err) begin
                            w_txn_count = r_txn_count + 16'd1;
                        end else begin
                            w_txn_count = r_txn_count;
                        end
                    end else begin
                        w_rsp_left = r_rsp_left - 3'd1;
                    end
                end else begin
                    w_state = RSP;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered
        w_cmd_ready = (w_state == IDLE) || (w_state == ADDR) || (w_state == DATA);
        w_strobe    = (w_state == STROBE);
        w_write     = (w_state == STROBE) && !w_is_read;
        w_rd        = ((w_state == STROBE) && w_is_read) || (w_state == RWAIT);
        w_rd_valid  = (w_state == RWAIT) && (w_cnt == C_DELAY);
        w_rsp_valid = (w_state == RSP);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge lb_clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_is_read   <= 1'b0;
            r_addr      <= 24'h00_0000;
            r_wdata     <= 32'h0000_0000;
            r_cnt       <= 4'd0;
            r_rsp_buf   <= 40'h00_0000_0000;
            r_rsp_left  <= 3'd0;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_strobe    <= 1'b0;
            r_rd        <= 1'b0;
            r_write     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_txn_count <= 16'h0000;
            r_err_count <= 8'h00;
        end else begin
            r_state     <= w_state;
            r_idx       <= w_idx;
            r_is_read   <= w_is_read;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_cnt       <= w_cnt;
            r_rsp_buf   <= w_rsp_buf;
            r_rsp_left  <= w_rsp_left;
            r_rsp_err   <= w_rsp_err;
            r_cmd_ready <= w_cmd_ready;
            r_rsp_valid <= w_rsp_valid;
            r_strobe    <= w_strobe;
            r_rd        <= w_rd;
            r_write     <= w_write;
            r_rd_valid  <= w_rd_valid;
            r_txn_count <= w_txn_count;
            r_err_count <= w_err_count;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_data    = r_rsp_buf[39:32];
    assign rsp_valid   = r_rsp_valid;
    assign lb_addr     = r_addr;
    assign lb_data_out = r_wdata;
    assign lb_strobe   = r_strobe;
    assign lb_rd       = r_rd;
    assign lb_write    = r_write;
    assign lb_rd_valid = r_rd_valid;
    assign txn_count   = r_txn_count;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_lb_stream_master.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for lb_stream_master (READ_DELAY = 3).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lb_stream_master;

    logic        clk;
    logic        reset;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [23:0] lb_addr;
    logic [31:0] lb_data_out;
    logic        lb_strobe;
    logic        lb_rd;
    logic        lb_write;
    logic        lb_rd_valid;
    logic [31:0] lb_din;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    lb_stream_master #(.READ_DELAY(3)) dut (
        .lb_clk      (clk),
        .reset       (reset),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .lb_addr     (lb_addr),
        .lb_data_out (lb_data_out),
        .lb_strobe   (lb_strobe),
        .lb_rd       (lb_rd),
        .lb_write    (lb_write),
        .lb_rd_valid (lb_rd_valid),
        .lb_din      (lb_din),
        .txn_count   (txn_count),
        .err_count   (err_count)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run wedges
    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one command byte; returns on the falling edge after acceptance
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Drain n response bytes (MSB first into 'bytes'); optional random backpressure
    task automatic get_rsp(input int n, input bit rand_ready, output logic [39:0] bytes);
        int got;
        int t;
        bit stalled;
        logic [7:0] held;
        got = 0; t = 0; stalled = 1'b0; held = 8'h00; bytes = 40'h0;
        while (got < n && t < 200) begin
            rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid) begin
                chk("cmd_ready_in_rsp", 64'(cmd_ready), 64'd0);
                if (stalled) chk("rsp_hold", 64'(rsp_data), 64'(held));
                if (rsp_ready) begin
                    bytes   = {bytes[31:0], rsp_data};
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = rsp_data;
                end
            end
            @(negedge clk);
            t++;
        end
        rsp_ready = 1'b0;
        chk("rsp_count", 64'(got), 64'(n));
        chk("rsp_valid_after", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [31:0] d, input logic [15:0] exp_txn);
        logic [39:0] r;
        send_byte(8'h57);
        send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
        send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
        // cycle N+1
        chk("wr_strobe", 64'(lb_strobe), 64'd1);
        chk("wr_write", 64'(lb_write), 64'd1);
        chk("wr_rd", 64'(lb_rd), 64'd0);
        chk("wr_addr", 64'(lb_addr), 64'(a));
        chk("wr_data", 64'(lb_data_out), 64'(d));
        chk("wr_rsp_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        // cycle N+2
        chk("wr_strobe_off", 64'(lb_strobe), 64'd0);
        chk("wr_write_off", 64'(lb_write), 64'd0);
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        get_rsp(1, 1'b0, r);
        chk("wr_rsp", 64'(r), 64'h77);
        chk("wr_txn", 64'(txn_count), 64'(exp_txn));
    endtask

    task automatic do_read(input logic [23:0] a, input logic [31:0] d, input bit rnd,
                           input logic [15:0] exp_txn);
        logic [39:0] r;
        lb_din = 32'h0BAD_0BAD;
        send_byte(8'h52);
        send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
        // strobe cycle
        chk("rd_strobe", 64'(lb_strobe), 64'd1);
        chk("rd_rd", 64'(lb_rd), 64'd1);
        chk("rd_write", 64'(lb_write), 64'd0);
        chk("rd_addr", 64'(lb_addr), 64'(a));
        chk("rd_cmd_ready", 64'(cmd_ready), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 3) lb_din = d;
            chk("rd_wait_rd", 64'(lb_rd), 64'd1);
            chk("rd_wait_strobe", 64'(lb_strobe), 64'd0);
            chk("rd_valid_time", 64'(lb_rd_valid), 64'(k == 3));
            chk("rd_wait_rsp", 64'(rsp_valid), 64'd0);
        end
        @(negedge clk);
        lb_din = 32'h0BAD_0BAD;
        chk("rd_rd_off", 64'(lb_rd), 64'd0);
        chk("rd_valid_off", 64'(lb_rd_valid), 64'd0);
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_first", 64'(rsp_data), 64'h72);
        get_rsp(5, rnd, r);
        chk("rd_rsp", 64'(r), {24'h0, 8'h72, d});
        chk("rd_txn", 64'(txn_count), 64'(exp_txn));
    endtask

    initial begin
        logic [39:0] r;
        reset     = 1'b1;
        cmd_data  = 8'h00;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        lb_din    = 32'h0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_addr", 64'(lb_addr), 64'd0);
        chk("rst_data", 64'(lb_data_out), 64'd0);
        chk("rst_txn", 64'(txn_count), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("cmd_ready_up", 64'(cmd_ready), 64'd1);

        // write
        do_write(24'h123456, 32'hDEAD_BEEF, 16'd1);
        repeat (2) @(negedge clk);
        chk("addr_hold", 64'(lb_addr), 64'h123456);
        chk("data_hold", 64'(lb_data_out), 64'hDEADBEEF);

        // read
        do_read(24'h000010, 32'hCAFE_F00D, 1'b0, 16'd2);
        chk("data_after_read", 64'(lb_data_out), 64'hDEADBEEF);

        // bad opcode then read
        send_byte(8'h00);
        get_rsp(1, 1'b0, r);
        chk("bad_rsp", 64'(r), 64'h3F);
        chk("bad_err", 64'(err_count), 64'd1);
        chk("bad_txn", 64'(txn_count), 64'd2);
        do_read(24'hABCDEF, 32'h1234_5678, 1'b0, 16'd3);

        // backpressure on read response
        do_read(24'h000020, 32'hCAFE_F00D, 1'b1, 16'd4);
        repeat (3) begin
            @(negedge clk);
            chk("no_extra_rsp", 64'(rsp_valid), 64'd0);
        end

        // reset while waiting for read data
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h30);
        @(negedge clk);
        chk("pre_rst_rd", 64'(lb_rd), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd", 64'(lb_rd), 64'd0);
        chk("mid_rst_strobe", 64'(lb_strobe), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("mid_rst_addr", 64'(lb_addr), 64'd0);
        chk("mid_rst_txn", 64'(txn_count), 64'd0);
        chk("mid_rst_err", 64'(err_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        lb_din = 32'h5555_AAAA;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_rd_valid", 64'(lb_rd_valid), 64'd0);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("post_rst_rd", 64'(lb_rd), 64'd0);
        end
        do_write(24'h00_0044, 32'h0102_0304, 16'd1);

        // err_count saturation
        for (int i = 0; i < 256; i++) begin
            send_byte(8'hFF);
            get_rsp(1, 1'b0, r);
            chk("sat_rsp", 64'(r), 64'h3F);
        end
        chk("err_sat", 64'(err_count), 64'hFF);
        chk("sat_txn", 64'(txn_count), 64'd1);

        // txn_count wrap
        @(negedge clk);
        force dut.r_txn_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_txn_count;
        @(negedge clk);
        chk("wrap_preload", 64'(txn_count), 64'hFFFE);
        do_write(24'h000001, 32'h0000_0001, 16'hFFFF);
        do_write(24'h000002, 32'h0000_0002, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lb_stream_master.md
# lb_stream_master

Local-bus initiator driven by a byte-stream command channel: parses read/write command packets, issues single localbus transactions (lb_addr/lb_strobe/lb_rd/lb_write/lb_data_out) toward application register space, captures read data after a fixed pipeline delay, and returns a byte-stream response. Sits in lb_clk domain beside marble_base as a second bus master (e.g. behind a UART or debug FIFO); external arbitration/muxing is out of scope.

## Interface
- READ_DELAY, 3, cycles from read strobe to lb_din valid (1..15)
- OP_WRITE, 8'h57, write opcode byte ('W')
- OP_READ, 8'h52, read opcode byte ('R')
- lb_clk  input  1  single clock, all logic rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- cmd_data  input  8  command byte
- cmd_valid  input  1  cmd_data valid
- cmd_ready  output  1  byte accepted when cmd_valid & cmd_ready
- rsp_data  output  8  response byte
- rsp_valid  output  1  rsp_data valid
- rsp_ready  input  1  response byte consumed when rsp_valid & rsp_ready
- lb_addr  output  24  bus address
- lb_data_out  output  32  write data
- lb_strobe  output  1  one-cycle transaction strobe
- lb_rd  output  1  read qualifier
- lb_write  output  1  write qualifier
- lb_rd_valid  output  1  one-cycle pulse on read-data capture cycle
- lb_din  input  32  read data from responder
- txn_count  output  16  completed-transaction counter (wraps)
- err_count  output  8  bad-opcode counter (saturates at 255)

## Operation
- States: IDLE, ADDR, DATA, STROBE, RWAIT, RSP.
- IDLE: cmd_ready=1. OP_WRITE or OP_READ -> ADDR (byte index 0). Any other byte -> RSP with single byte 8'h3F ('?'), err_count+1.
- ADDR: accept 3 bytes, big-endian into lb_addr[23:16],[15:8],[7:0]. After 3rd: write -> DATA, read -> STROBE.
- DATA: accept 4 bytes big-endian into lb_data_out[31:0] -> STROBE.
- STROBE: cmd_ready=0. Write: lb_strobe=lb_write=1 one cycle; response = 1 byte 8'h77 ('w'); -> RSP. Read: lb_strobe=lb_rd=1 one cycle -> RWAIT.
- RWAIT: lb_rd held 1; counter runs READ_DELAY cycles after strobe; on final cycle lb_din latched, lb_rd_valid=1 one cycle; response = 8'h72 ('r') then 4 data bytes MSB first; -> RSP.
- RSP: cmd_ready=0; present bytes in order, each held stable until rsp_ready; after last handshake -> IDLE, txn_count+1 (not for '?').
- lb_addr and lb_data_out hold last values between transactions; only change during ADDR/DATA byte acceptance.
- cmd_ready is 0 in STROBE, RWAIT, RSP; no command bytes lost or reordered.

## Timing
- Reset values: cmd_ready=0 during reset, 1 first cycle after deassert; rsp_valid=0, rsp_data=0, lb_addr=0, lb_data_out=0, lb_strobe=lb_rd=lb_write=lb_rd_valid=0, txn_count=0, err_count=0.
- Last write byte accepted at cycle N: lb_strobe/lb_write high at N+1 only; rsp_valid high from N+2.
- Last address byte of read at N: lb_strobe/lb_rd high at N+1; lb_rd stays high N+1..N+1+READ_DELAY; lb_din sampled and lb_rd_valid=1 at N+1+READ_DELAY; rsp_valid ('r') from N+2+READ_DELAY.
- Response throughput: one byte per cycle when rsp_ready held high; rsp_valid never deasserts before handshake.
- Reset mid-transaction (any state): abort, no further strobes, partial response discarded, counters cleared.
- cmd_valid gaps inside a packet allowed indefinitely; no timeout.
- txn_count wraps 16'hFFFF -> 0; err_count sticks at 8'hFF.

## Test plan
- Write: bytes 57 12 34 56 DE AD BE EF -> one-cycle lb_strobe&lb_write with lb_addr=24'h123456, lb_data_out=32'hDEADBEEF; response 77; txn_count=1.
- Read, READ_DELAY=3, responder drives lb_din=32'hCAFEF00D at strobe+3: bytes 52 00 00 10 -> lb_rd_valid exactly at strobe+3; response 72 CA FE F0 0D.
- Bad opcode 0x00 then valid read -> response 3F, err_count=1, then read completes normally; txn_count unchanged by 3F.
- Backpressure: rsp_ready toggled 0/1 randomly during read response -> bytes 72 CA FE F0 0D exactly once, in order; cmd_ready=0 until last handshake.
- Reset asserted in RWAIT -> all outputs to reset values same cycle; no lb_rd_valid; next command executes cleanly.
- Counter wrap: preload 65535 writes (or force) -> txn_count 16'hFFFF then 0 after next transaction.
